// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and the iterative 32-bit divider.
// Latches operands, drives start/cancel, stalls EX and returns a one-cycle HI/LO write.
module div_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush,
    output logic        div_start,
    output logic        div_cancel,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_done,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dbz,
    output logic        timeout_err
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StBusy   = 2'd1;
    localparam logic [1:0] StResult = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    logic [1:0]     state_q, state_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           drain_q, drain_d;
    logic [31:0]    op1_q, op1_d;
    logic [31:0]    op2_q, op2_d;
    logic           signed_q, signed_d;
    logic           dbz_q, dbz_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic           cancel_q, cancel_d;
    logic           tmo_q, tmo_d;

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        drain_d  = drain_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        signed_d = signed_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cancel_d = 1'b0;
        tmo_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (div_req && !flush) begin
                    op1_d    = op1_i;
                    op2_d    = op2_i;
                    signed_d = div_signed_i;
                    dbz_d    = (op2_i == 32'd0);
                    wd_d     = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (flush) begin
                    cancel_d = 1'b1;
                    drain_d  = 1'b0;
                    state_d  = StDrain;
                end else if (div_done) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    state_d = StResult;
                end else if (wd_q == WdLast) begin
                    tmo_d    = 1'b1;
                    cancel_d = 1'b1;
                    drain_d  = 1'b0;
                    state_d  = StDrain;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StResult: begin
                drain_d = 1'b0;
                state_d = StDrain;
            end
            StDrain: begin
                // Two cycles with start low let the divider fall back to its idle state.
                if (drain_q) begin
                    state_d = StIdle;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wd_q     <= '0;
            drain_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cancel_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            drain_q  <= drain_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            signed_q <= signed_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cancel_q <= cancel_d;
            tmo_q    <= tmo_d;
        end
    end

    assign div_start   = (state_q == StBusy);
    assign div_cancel  = cancel_q;
    assign div_signed  = signed_q;
    assign div_op1     = op1_q;
    assign div_op2     = op2_q;
    assign hilo_we     = (state_q == StResult) && !flush;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign dbz         = dbz_q;
    assign timeout_err = tmo_q;
    assign stallreq    = ((state_q == StIdle) && div_req && !flush) || (state_q == StBusy) ||
                         ((state_q == StDrain) && div_req);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative-divider model attached.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req;
    logic        div_signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        flush;
    logic        div_start;
    logic        div_cancel;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_done;
    logic [63:0] div_result;
    logic        stallreq;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        dbz;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int gap;
    int n;
    bit done_en = 1'b1;

    localparam int Lat = 16;

    always #5 clk = ~clk;

    div_ctrl #(.TIMEOUT(40)) dut (
        .clk         (clk),
        .rst         (rst),
        .div_req     (div_req),
        .div_signed_i(div_signed_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .flush       (flush),
        .div_start   (div_start),
        .div_cancel  (div_cancel),
        .div_signed  (div_signed),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .div_done    (div_done),
        .div_result  (div_result),
        .stallreq    (stallreq),
        .hilo_we     (hilo_we),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .dbz         (dbz),
        .timeout_err (timeout_err)
    );

    // Divider model: result appears Lat cycles after start, held while start stays high.
    int mcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt       <= 0;
            div_done   <= 1'b0;
            div_result <= '0;
        end else if (!div_start || div_cancel || !done_en) begin
            mcnt     <= 0;
            div_done <= 1'b0;
        end else if (mcnt == Lat - 1) begin
            div_done <= 1'b1;
            if (div_op2 == 32'd0) begin
                div_result <= '0;
            end else if (div_signed) begin
                div_result <= {32'($signed(div_op1) % $signed(div_op2)),
                               32'($signed(div_op1) / $signed(div_op2))};
            end else begin
                div_result <= {div_op1 % div_op2, div_op1 / div_op2};
            end
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues a request and runs to the hilo_we cycle; gap = cycles before div_start rises.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input string tag, output int g);
        bit seen = 0, stall_low = 0, tmo = 0, hit = 0;
        g = 0;
        op1_i = a; op2_i = b; div_signed_i = s; div_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (timeout_err) tmo = 1;
            if (hilo_we) begin
                hit = 1;
                break;
            end
            if (!stallreq) stall_low = 1;
            if (!seen && div_start) begin
                seen = 1;
                check({tag, "_op1"}, 64'(div_op1), 64'(a));
                check({tag, "_op2"}, 64'(div_op2), 64'(b));
                check({tag, "_sgn"}, 64'(div_signed), 64'(s));
            end
            if (!seen) g++;
        end
        check({tag, "_hilo_we"}, 64'(hit), 64'd1);
        check({tag, "_stall_at_we"}, 64'(stallreq), 64'd0);
        check({tag, "_hi"}, 64'(hi_o), 64'(eh));
        check({tag, "_lo"}, 64'(lo_o), 64'(el));
        check({tag, "_dbz"}, 64'(dbz), 64'(ed));
        check({tag, "_stall_gap"}, 64'(stall_low), 64'd0);
        check({tag, "_no_tmo"}, 64'(tmo), 64'd0);
    endtask

    // Drops the request after the write and walks through DRAIN back to IDLE.
    task automatic settle(input string tag);
        div_req = 1'b0;
        @(negedge clk);
        check({tag, "_one_we"}, 64'(hilo_we), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_idle_stall"}, 64'(stallreq), 64'd0);
        check({tag, "_idle_start"}, 64'(div_start), 64'd0);
    endtask

    initial begin
        rst = 1'b1; div_req = 1'b0; div_signed_i = 1'b0; op1_i = '0; op2_i = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_start", 64'(div_start), 64'd0);
        check("rst_outs", 64'({stallreq, hilo_we, dbz, timeout_err, div_cancel}), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);

        do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, "u100_7", gap);
        settle("u100_7");

        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "s_m7_2", gap);
        settle("s_m7_2");

        do_div(32'd5, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, "dbz", gap);
        settle("dbz");

        // Flush ten cycles into BUSY.
        op1_i = 32'd100; op2_i = 32'd7; div_signed_i = 1'b0; div_req = 1'b1;
        n = 0;
        while (!div_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (9) @(negedge clk);
        check("fl_busy", 64'(div_start), 64'd1);
        flush = 1'b1; div_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("fl_cancel", 64'(div_cancel), 64'd1);
        check("fl_start_lo", 64'(div_start), 64'd0);
        check("fl_no_we", 64'(hilo_we), 64'd0);
        @(negedge clk);
        check("fl_cancel_1cyc", 64'(div_cancel), 64'd0);
        @(negedge clk);
        do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, "after_fl", gap);
        settle("after_fl");

        // Back-to-back: second request waits through RESULT, two DRAIN cycles and IDLE.
        do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, "b2b_a", gap);
        do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0, "b2b_b", gap);
        check("b2b_gap", 64'(gap), 64'd3);
        settle("b2b_b");

        // Watchdog: divider never completes.
        done_en = 1'b0;
        op1_i = 32'd77; op2_i = 32'd3; div_req = 1'b1;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (timeout_err) break;
            check("tmo_no_we", 64'(hilo_we), 64'd0);
            if (div_start) n++;
        end
        check("tmo_pulse", 64'(timeout_err), 64'd1);
        check("tmo_cycles", 64'(n), 64'd40);
        check("tmo_cancel", 64'(div_cancel), 64'd1);
        div_req = 1'b0;
        @(negedge clk);
        check("tmo_1cyc", 64'(timeout_err), 64'd0);
        @(negedge clk);
        check("tmo_idle", 64'(stallreq), 64'd0);
        done_en = 1'b1;

        // Asynchronous reset in BUSY.
        op1_i = 32'd50; op2_i = 32'd0; div_req = 1'b1;
        repeat (4) @(negedge clk);
        check("rb_busy", 64'(div_start), 64'd1);
        rst = 1'b1; div_req = 1'b0;
        #1;
        check("rb_start", 64'(div_start), 64'd0);
        check("rb_outs", 64'({stallreq, hilo_we, dbz, timeout_err, div_cancel, div_signed}),
              64'd0);
        check("rb_hilo", {hi_o, lo_o}, 64'd0);
        check("rb_ops", {div_op1, div_op2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0, "post_rst", gap);
        settle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the iterative 32-bit divider in the EX stage. It accepts DIV/DIVU requests from EX and latches the operands. It drives the divider's start/cancel handshake, holds the pipeline stalled until the quotient and remainder are ready, and returns them as a one-cycle HI/LO write. It also handles pipeline flush, divide-by-zero flagging, and a watchdog timeout, so EX logic never talks to the divider directly.

## Interface
- TIMEOUT, 40: max cycles in BUSY without `div_done` before abort (must exceed divider latency).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_req  in  1  EX holds a DIV/DIVU instruction; level, held while stalled.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- op1_i  in  32  dividend.
- op2_i  in  32  divisor.
- flush  in  1  pipeline flush/exception; kills any in-flight divide.
- div_start  out  1  divider start_flag.
- div_cancel  out  1  divider cancel_flag.
- div_signed  out  1  divider signed_flag (latched).
- div_op1  out  32  divider opdata1 (latched).
- div_op2  out  32  divider opdata2 (latched).
- div_done  in  1  divider complete_flag.
- div_result  in  64  divider result, {remainder[63:32], quotient[31:0]}.
- stallreq  out  1  stall request to pipeline controller.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi_o  out  32  remainder, valid with hilo_we.
- lo_o  out  32  quotient, valid with hilo_we.
- dbz  out  1  divide-by-zero flag, valid with hilo_we.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY, RESULT, DRAIN. Reset → IDLE. All outputs and registers reset to 0.
- IDLE:
  - If `div_req & !flush`: latch op1/op2/signed, set dbz_r = (op2_i == 0), clear watchdog, assert div_start, go BUSY.
  - Otherwise stay in IDLE with div_start = 0.
- BUSY:
  - div_start = 1; operands and div_signed held constant; watchdog increments each cycle.
  - flush: div_start = 0, div_cancel = 1, go DRAIN. No hilo_we.
  - Else if div_done: capture hi_o = div_result[63:32], lo_o = div_result[31:0], go RESULT.
  - Else if watchdog == TIMEOUT-1: pulse timeout_err, div_cancel = 1, div_start = 0, go DRAIN.
  - Priority: flush > div_done > timeout.
- RESULT:
  - hilo_we = 1 and stallreq = 0 for exactly one cycle, so the instruction advances.
  - div_start = 0; go DRAIN.
  - A flush in this cycle suppresses hilo_we; the result is discarded.
- DRAIN:
  - div_start = 0 for 2 cycles (counter), so the divider exits its exception/finish states and returns to idle.
  - Then go IDLE. New requests are not accepted here.
- stallreq = (IDLE & div_req & !flush) | BUSY | (DRAIN & div_req). It is never asserted in RESULT.
- Result values come from the divider unmodified. The controller does no sign correction.
- On a divisor of 0, the divider returns 0. The controller still writes HI/LO (0/0) with dbz = 1.
- hi_o/lo_o/dbz hold their last captured values between writes. Only hilo_we qualifies them.

## Timing
- Accept: div_start rises the cycle after div_req is sampled in IDLE.
- Result: hilo_we is asserted the cycle after div_done is sampled. Total request-to-write latency = divider latency + 2.
- Back-to-back divides: minimum spacing = divider latency + 4 cycles (RESULT + 2 DRAIN + IDLE accept).
- Flush in BUSY: div_cancel is high for the first DRAIN cycle only. IDLE is reached 2 cycles later.
- Asynchronous rst mid-operation: immediate return to IDLE with all outputs at 0. The divider is reset by the same reset tree.

## Test plan
- Unsigned 100 / 7, div_signed_i = 0 → one hilo_we pulse with lo_o = 14, hi_o = 2, dbz = 0. stallreq is high from request until that cycle.
- Signed −7 / 2 (op1 = 0xFFFFFFF9) → lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF. These are the divider's output, passed through unchanged.
- Divisor 0, op1 = 5 → hilo_we with hi_o = 0, lo_o = 0, dbz = 1. No timeout_err.
- flush 10 cycles into BUSY → div_cancel pulses for one cycle, no hilo_we. The next request 100/7 completes correctly.
- Two consecutive requests, 100/7 then 9/3 → two hilo_we pulses (14/2, then 3/0), separated by ≥ 4 non-BUSY cycles. The second request is stalled through DRAIN.
- div_done tied 0 with TIMEOUT = 40 → timeout_err pulses 40 cycles after entering BUSY, then DRAIN → IDLE. Also: assert rst in BUSY → all outputs 0 immediately.
